multicycle_ctrl_v2: RTL and testbench
=====================================

// Module: multicycle_ctrl_v2
// PURPOSE
//  Parametrised multicycle CPU control FSM: fetch/decode/execute sequencing plus datapath selects and enables.
//  Adds over the previous generation: memory wait-state handshake with bus timeout, and call-stack depth tracking
//  with overflow/underflow faults. Also adds a vectored interrupt with RETI, and a resumable halt.
//  Sits between the instruction register (opcode), ALU flags and the datapath/stack/memory control pins.
// PARAMETERS
//  STACK_DEPTH  8   return-stack entries tracked; depth counter width = $clog2(STACK_DEPTH+1)
//  MEM_TIMEOUT  15  max cycles to wait for mem_ready before bus fault (>=1)
//  IRQ_EN       1   1 = irq input honoured, 0 = irq ignored (irq_ack stays 0)
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-high reset
//  opcode     in   6  IR opcode [5:0]
//  z, s       in   1  ALU zero / sign flags (held by datapath)
//  mem_ready  in   1  memory completes the current read/write this cycle
//  irq        in   1  level interrupt request
//  resume     in   1  leave HALTED
//  we_pc, we_reg, we_alu, we_rmem, we_wd3, we3  out 1  datapath register enables
//  s_pc       out  2  00 PC+1, 01 imm target, 10 stack top, 11 IRQ vector
//  s_wd3      out  2  00 ALU, 01 immediate, 10 memory
//  s_addr, s_io_wr  out 1  address / write-data selects
//  op_alu     out  3  = opcode[2:0] for ALU ops, else 0
//  push, pop  out  1  return-stack strobes, single cycle
//  read, write  out 1  memory request, held until mem_ready or timeout
//  irq_ack    out  1  one-cycle pulse on interrupt entry
//  halted     out  1  high in HALTED
//  fault      out  2  00 none, 01 stack overflow, 10 stack underflow, 11 bus timeout; sticky
//  state_dbg  out  4  current state encoding
// BEHAVIOUR
//  Reset state: RST. All outputs are 0 during reset and in RST. depth=0, wait counter=0, in_isr=0, fault=00.
//  Opcodes:
//   ALU 111xxx; J 110000; JPOS 110001; JNZ 110010; JZ 110011; JAL 11010x; JR 11011x;
//   LI 10100x; SW_R_R 101010; LW_R_R 101011; LW_ADDR_R 1011xx; SW_ADDR_R 1000xx; STI 1001xx;
//   NOP 000000; HALT 000001; RETI 000010. Any other opcode is executed as NOP.
//  States (4b): RST=0 IF=1 ID=2 EX=3 WB=4 JI=5 JC=6 RMEM=7 WMEM=8 HALTED=9 IRQ=10 FAULT=11.
//  Transitions:
//   RST->ID.
//   IF->IRQ if IRQ_EN&&irq&&!in_isr, else ID.
//   ID: ALU,LI->EX. J,JAL,JR,RETI->JI. JZ,JNZ,JPOS->JC. LW*->RMEM. SW*,STI->WMEM. HALT->HALTED. Others->IF.
//   EX->WB; WB->IF; JC->IF.
//   JI->IF, or ->FAULT when push at depth==STACK_DEPTH or pop at depth==0 (strobe suppressed).
//   RMEM->WB and WMEM->IF on mem_ready. After MEM_TIMEOUT waiting cycles without mem_ready -> FAULT (11).
//   HALTED->IF on resume. IRQ->ID, or ->FAULT on overflow. FAULT is terminal until reset.
//  Per-state enables:
//   IF we_pc. ID we_reg. EX we_alu,we_wd3. WB we3. WMEM write.
//   RMEM read; we_rmem,we_wd3 only in the mem_ready cycle.
//   IRQ we_pc, push, irq_ack, s_pc=11.
//  s_pc decode from opcode in every state except IRQ (so IF commits the jump):
//   J/JAL 01; JR/RETI 10; JZ z?01:00; JNZ z?00:01; JPOS (!z&&!s)?01:00; else 00.
//   s_wd3/s_addr/s_io_wr per opcode: LI 01/0/0; LW_ADDR_R 10/1/0; LW_R_R 10/0/0; SW_R_R 00/0/0; SW_ADDR_R 00/1/0; STI 10/1/1.
//  push in JI for JAL; pop in JI for JR/RETI. depth +1 on push, -1 on pop, never wraps.
//  RETI in JI clears in_isr; IRQ entry sets it. irq is ignored while in_isr (no nesting).
//  Wait counter clears on entering RMEM/WMEM. read/write drop in the cycle after mem_ready.
//  reset mid-operation: immediate return to RST. Any in-flight memory request is dropped combinationally.
// TESTING
//  ALU 111010 after reset -> states 0,2,3,4,1; op_alu=010; we3 high exactly 1 cycle in WB.
//  LW_R_R, mem_ready low 3 cycles -> read held 4 cycles; we_rmem 1 cycle with ready; then WB.
//  WMEM with mem_ready stuck low, MEM_TIMEOUT=15 -> FAULT after 15 wait cycles; fault=11; write=0; stays until reset.
//  9 JAL with STACK_DEPTH=8 -> 8 push pulses; 9th goes to FAULT with fault=01 and no push. JR at depth 0 -> fault=10.
//  irq high during IF -> IRQ state: irq_ack/push/we_pc 1 cycle, s_pc=11. Second irq is ignored until RETI, then taken.
//  HALT -> halted=1 for 20 cycles; resume pulse -> IF next cycle. JZ with z=1 -> s_pc=01 in JC and IF.

Source files
------------

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle CPU control FSM: fetch/decode/execute sequencing with memory wait
// states and bus timeout, return-stack depth tracking, vectored IRQ/RETI and halt.
module multicycle_ctrl_v2 #(
  parameter int STACK_DEPTH = 8,
  parameter int MEM_TIMEOUT = 15,
  parameter bit IRQ_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       z,
  input  logic       s,
  input  logic       mem_ready,
  input  logic       irq,
  input  logic       resume,
  output logic       we_pc,
  output logic       we_reg,
  output logic       we_alu,
  output logic       we_rmem,
  output logic       we_wd3,
  output logic       we3,
  output logic [1:0] s_pc,
  output logic [1:0] s_wd3,
  output logic       s_addr,
  output logic       s_io_wr,
  output logic [2:0] op_alu,
  output logic       push,
  output logic       pop,
  output logic       read,
  output logic       write,
  output logic       irq_ack,
  output logic       halted,
  output logic [1:0] fault,
  output logic [3:0] state_dbg
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_IF     = 4'd1,
    S_ID     = 4'd2,
    S_EX     = 4'd3,
    S_WB     = 4'd4,
    S_JI     = 4'd5,
    S_JC     = 4'd6,
    S_RMEM   = 4'd7,
    S_WMEM   = 4'd8,
    S_HALTED = 4'd9,
    S_IRQ    = 4'd10,
    S_FAULT  = 4'd11
  } state_t;

  localparam logic [1:0] F_NONE = 2'b00;
  localparam logic [1:0] F_OVF  = 2'b01;
  localparam logic [1:0] F_UNF  = 2'b10;
  localparam logic [1:0] F_BUS  = 2'b11;

  state_t          state_q, state_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic            in_isr_q, in_isr_d;
  logic [1:0]      fault_q, fault_d;

  // Opcode classes
  logic is_alu, is_j, is_jpos, is_jnz, is_jz, is_jal, is_jr, is_li;
  logic is_sw_rr, is_lw_rr, is_lw_ar, is_sw_ar, is_sti, is_halt, is_reti;
  logic is_lw, is_sw, stack_full, stack_empty, mem_timeout;
  logic push_c, pop_c;

  always_comb begin
    is_alu   = (opcode[5:3] == 3'b111);
    is_j     = (opcode == 6'b110000);
    is_jpos  = (opcode == 6'b110001);
    is_jnz   = (opcode == 6'b110010);
    is_jz    = (opcode == 6'b110011);
    is_jal   = (opcode[5:1] == 5'b11010);
    is_jr    = (opcode[5:1] == 5'b11011);
    is_li    = (opcode[5:1] == 5'b10100);
    is_sw_rr = (opcode == 6'b101010);
    is_lw_rr = (opcode == 6'b101011);
    is_lw_ar = (opcode[5:2] == 4'b1011);
    is_sw_ar = (opcode[5:2] == 4'b1000);
    is_sti   = (opcode[5:2] == 4'b1001);
    is_halt  = (opcode == 6'b000001);
    is_reti  = (opcode == 6'b000010);
    is_lw    = is_lw_rr | is_lw_ar;
    is_sw    = is_sw_rr | is_sw_ar | is_sti;
    stack_full  = (depth_q == DW'(STACK_DEPTH));
    stack_empty = (depth_q == '0);
    mem_timeout = (wcnt_q == CW'(MEM_TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RST;
      depth_q  <= '0;
      wcnt_q   <= '0;
      in_isr_q <= 1'b0;
      fault_q  <= F_NONE;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      wcnt_q   <= wcnt_d;
      in_isr_q <= in_isr_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    wcnt_d   = wcnt_q;
    in_isr_d = in_isr_q;
    fault_d  = fault_q;
    push_c   = 1'b0;
    pop_c    = 1'b0;

    unique case (state_q)
      S_RST: state_d = S_ID;
      S_IF:  state_d = (IRQ_EN && irq && !in_isr_q) ? S_IRQ : S_ID;
      S_ID: begin
        if (is_alu || is_li)                      state_d = S_EX;
        else if (is_j || is_jal || is_jr || is_reti) state_d = S_JI;
        else if (is_jz || is_jnz || is_jpos)      state_d = S_JC;
        else if (is_lw) begin
          state_d = S_RMEM;
          wcnt_d  = '0;
        end else if (is_sw) begin
          state_d = S_WMEM;
          wcnt_d  = '0;
        end else if (is_halt)                     state_d = S_HALTED;
        else                                      state_d = S_IF;
      end
      S_EX: state_d = S_WB;
      S_WB: state_d = S_IF;
      S_JC: state_d = S_IF;
      S_JI: begin
        state_d = S_IF;
        // A stack fault suppresses the strobe so the return stack stays consistent
        if (is_jal) begin
          if (stack_full) begin
            state_d = S_FAULT;
            fault_d = F_OVF;
          end else begin
            push_c  = 1'b1;
            depth_d = depth_q + DW'(1);
          end
        end else if (is_jr || is_reti) begin
          if (stack_empty) begin
            state_d = S_FAULT;
            fault_d = F_UNF;
          end else begin
            pop_c   = 1'b1;
            depth_d = depth_q - DW'(1);
            if (is_reti) in_isr_d = 1'b0;
          end
        end
      end
      S_RMEM, S_WMEM: begin
        if (mem_ready) begin
          state_d = (state_q == S_RMEM) ? S_WB : S_IF;
        end else if (mem_timeout) begin
          state_d = S_FAULT;
          fault_d = F_BUS;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      S_HALTED: if (resume) state_d = S_IF;
      S_IRQ: begin
        if (stack_full) begin
          state_d = S_FAULT;
          fault_d = F_OVF;
        end else begin
          state_d  = S_ID;
          push_c   = 1'b1;
          depth_d  = depth_q + DW'(1);
          in_isr_d = 1'b1;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_RST;
    endcase
  end

  // Output decode; everything is forced low in RST and while reset is asserted
  always_comb begin
    we_pc     = 1'b0;
    we_reg    = 1'b0;
    we_alu    = 1'b0;
    we_rmem   = 1'b0;
    we_wd3    = 1'b0;
    we3       = 1'b0;
    s_pc      = 2'b00;
    s_wd3     = 2'b00;
    s_addr    = 1'b0;
    s_io_wr   = 1'b0;
    op_alu    = 3'b000;
    read      = 1'b0;
    write     = 1'b0;
    irq_ack   = 1'b0;
    halted    = 1'b0;
    fault     = 2'b00;
    state_dbg = 4'd0;
    push      = push_c & ~reset;
    pop       = pop_c & ~reset;

    if (!reset && state_q != S_RST) begin
      state_dbg = state_q;
      fault     = fault_q;
      if (is_alu) op_alu = opcode[2:0];

      if (is_j || is_jal)                s_pc = 2'b01;
      else if (is_jr || is_reti)         s_pc = 2'b10;
      else if (is_jz)                    s_pc = z ? 2'b01 : 2'b00;
      else if (is_jnz)                   s_pc = z ? 2'b00 : 2'b01;
      else if (is_jpos)                  s_pc = (!z && !s) ? 2'b01 : 2'b00;

      if (is_li)         s_wd3 = 2'b01;
      else if (is_lw)    s_wd3 = 2'b10;
      else if (is_sti)   s_wd3 = 2'b10;
      s_addr  = is_lw_ar | is_sw_ar | is_sti;
      s_io_wr = is_sti;

      unique case (state_q)
        S_IF:   we_pc = 1'b1;
        S_ID:   we_reg = 1'b1;
        S_EX: begin
          we_alu = 1'b1;
          we_wd3 = 1'b1;
        end
        S_WB:   we3 = 1'b1;
        S_RMEM: begin
          read    = 1'b1;
          we_rmem = mem_ready;
          we_wd3  = mem_ready;
        end
        S_WMEM:   write = 1'b1;
        S_HALTED: halted = 1'b1;
        S_IRQ: begin
          we_pc   = 1'b1;
          irq_ack = 1'b1;
          s_pc    = 2'b11;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
module tb_multicycle_ctrl_v2;
  localparam int SD = 8;
  localparam int MT = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = '0;
  logic z = 0, s = 0, mem_ready = 0, irq = 0, resume = 0;
  logic we_pc, we_reg, we_alu, we_rmem, we_wd3, we3, s_addr, s_io_wr;
  logic push, pop, read, write, irq_ack, halted;
  logic [1:0] s_pc, s_wd3, fault;
  logic [2:0] op_alu;
  logic [3:0] state_dbg;

  multicycle_ctrl_v2 #(.STACK_DEPTH(SD), .MEM_TIMEOUT(MT), .IRQ_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .s(s), .mem_ready(mem_ready),
    .irq(irq), .resume(resume), .we_pc(we_pc), .we_reg(we_reg), .we_alu(we_alu),
    .we_rmem(we_rmem), .we_wd3(we_wd3), .we3(we3), .s_pc(s_pc), .s_wd3(s_wd3),
    .s_addr(s_addr), .s_io_wr(s_io_wr), .op_alu(op_alu), .push(push), .pop(pop),
    .read(read), .write(write), .irq_ack(irq_ack), .halted(halted), .fault(fault),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] op_alu;
    logic [1:0] s_pc, s_wd3;
    logic s_addr, s_io_wr, we_pc, we_reg, we_alu, we_rmem, we_wd3, we3;
    logic push, pop, read, write, irq_ack, halted;
    logic [1:0] fault;
  } obs_t;

  typedef struct packed {
    logic rst;
    logic [5:0] op;
    logic z, s, rdy, irq, res;
  } stim_t;

  typedef enum {C_ALU, C_J, C_JPOS, C_JNZ, C_JZ, C_JAL, C_JR, C_LI, C_SWRR, C_LWRR,
                C_LWAR, C_SWAR, C_STI, C_NOP, C_HALT, C_RETI} cls_t;

  stim_t stim_q[$];
  obs_t  exp_q[$];
  int checks = 0, errors = 0;

  int depth = 0;
  bit in_isr = 0, pend_irq = 0;

  function automatic cls_t classify(input logic [5:0] op);
    casez (op)
      6'b111???: return C_ALU;
      6'b110000: return C_J;
      6'b110001: return C_JPOS;
      6'b110010: return C_JNZ;
      6'b110011: return C_JZ;
      6'b11010?: return C_JAL;
      6'b11011?: return C_JR;
      6'b10100?: return C_LI;
      6'b101010: return C_SWRR;
      6'b101011: return C_LWRR;
      6'b1011??: return C_LWAR;
      6'b1000??: return C_SWAR;
      6'b1001??: return C_STI;
      6'b000001: return C_HALT;
      6'b000010: return C_RETI;
      default:   return C_NOP;
    endcase
  endfunction

  function automatic obs_t base(input logic [5:0] op, input logic zz, input logic ss);
    obs_t o = '0;
    cls_t c = classify(op);
    if (c == C_ALU) o.op_alu = op[2:0];
    case (c)
      C_J, C_JAL:  o.s_pc = 2'b01;
      C_JR, C_RETI: o.s_pc = 2'b10;
      C_JZ:   o.s_pc = zz ? 2'b01 : 2'b00;
      C_JNZ:  o.s_pc = zz ? 2'b00 : 2'b01;
      C_JPOS: o.s_pc = (!zz && !ss) ? 2'b01 : 2'b00;
      default: o.s_pc = 2'b00;
    endcase
    case (c)
      C_LI:   o.s_wd3 = 2'b01;
      C_LWAR: begin o.s_wd3 = 2'b10; o.s_addr = 1'b1; end
      C_LWRR: o.s_wd3 = 2'b10;
      C_SWAR: o.s_addr = 1'b1;
      C_STI:  begin o.s_wd3 = 2'b10; o.s_addr = 1'b1; o.s_io_wr = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic cyc(input stim_t si, input obs_t o);
    stim_q.push_back(si);
    exp_q.push_back(o);
  endtask

  task automatic do_reset();
    stim_t si = '0;
    si.rst = 1'b1;
    cyc(si, '0);
    cyc(si, '0);
    si.rst = 1'b0;
    cyc(si, '0);
    depth = 0; in_isr = 0; pend_irq = 0;
  endtask

  task automatic do_fault(input stim_t si, input obs_t b, input logic [1:0] code);
    obs_t o = b;
    o.st = 4'd11;
    o.fault = code;
    for (int i = 0; i < 3; i++) cyc(si, o);
    do_reset();
  endtask

  task automatic run_instr(input logic [5:0] op, input logic zz, input logic ss,
                           input int wt, input int hl, input bit irq_if);
    stim_t si = '0;
    obs_t b, o;
    cls_t c = classify(op);
    si.op = op; si.z = zz; si.s = ss;
    b = base(op, zz, ss);
    if (pend_irq) begin
      o = b; o.st = 4'd10; o.s_pc = 2'b11; o.we_pc = 1; o.push = 1; o.irq_ack = 1;
      cyc(si, o);
      depth++; in_isr = 1; pend_irq = 0;
    end
    o = b; o.st = 4'd2; o.we_reg = 1; cyc(si, o);
    case (c)
      C_ALU, C_LI: begin
        o = b; o.st = 4'd3; o.we_alu = 1; o.we_wd3 = 1; cyc(si, o);
        o = b; o.st = 4'd4; o.we3 = 1; cyc(si, o);
      end
      C_J: begin o = b; o.st = 4'd5; cyc(si, o); end
      C_JAL: begin
        o = b; o.st = 4'd5;
        if (depth == SD) begin cyc(si, o); do_fault(si, b, 2'b01); return; end
        o.push = 1; cyc(si, o); depth++;
      end
      C_JR, C_RETI: begin
        o = b; o.st = 4'd5;
        if (depth == 0) begin cyc(si, o); do_fault(si, b, 2'b10); return; end
        o.pop = 1; cyc(si, o); depth--;
        if (c == C_RETI) in_isr = 0;
      end
      C_JZ, C_JNZ, C_JPOS: begin o = b; o.st = 4'd6; cyc(si, o); end
      C_LWRR, C_LWAR, C_SWRR, C_SWAR, C_STI: begin
        bit ld = (c == C_LWRR || c == C_LWAR);
        o = b; o.st = ld ? 4'd7 : 4'd8; o.read = ld; o.write = !ld;
        if (wt >= MT) begin
          for (int i = 0; i < MT; i++) cyc(si, o);
          do_fault(si, b, 2'b11);
          return;
        end
        for (int i = 0; i < wt; i++) cyc(si, o);
        si.rdy = 1; o.we_rmem = ld; o.we_wd3 = ld; cyc(si, o); si.rdy = 0;
        if (ld) begin o = b; o.st = 4'd4; o.we3 = 1; cyc(si, o); end
      end
      C_HALT: begin
        o = b; o.st = 4'd9; o.halted = 1;
        for (int i = 0; i < hl; i++) begin si.res = (i == hl - 1); cyc(si, o); end
        si.res = 0;
      end
      default: ;
    endcase
    si.irq = irq_if && (in_isr || depth < SD);
    o = b; o.st = 4'd1; o.we_pc = 1; cyc(si, o);
    if (si.irq && !in_isr) pend_irq = 1;
  endtask

  initial begin
    int wt, r;
    do_reset();
    run_instr(6'b111010, 0, 0, 0, 1, 0);
    run_instr(6'b101011, 0, 0, 3, 1, 0);
    run_instr(6'b110011, 1, 0, 0, 1, 0);
    run_instr(6'b110011, 0, 1, 0, 1, 0);
    run_instr(6'b000001, 0, 0, 0, 20, 0);
    for (int i = 0; i < 9; i++) run_instr(6'b110100, 0, 0, 0, 1, 0);
    run_instr(6'b110110, 0, 0, 0, 1, 0);
    run_instr(6'b000000, 0, 0, 0, 1, 1);
    run_instr(6'b000000, 0, 0, 0, 1, 1);
    run_instr(6'b000010, 0, 0, 0, 1, 1);
    run_instr(6'b000010, 0, 0, 0, 1, 0);
    run_instr(6'b100101, 0, 0, 2, 1, 0);
    run_instr(6'b101001, 0, 0, 0, 1, 0);
    run_instr(6'b110010, 0, 0, 0, 1, 0);
    run_instr(6'b110001, 0, 0, 0, 1, 0);
    run_instr(6'b110000, 0, 0, 0, 1, 0);
    run_instr(6'b101110, 0, 0, 14, 1, 0);
    run_instr(6'b100001, 0, 0, MT, 1, 0);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      wt = (r < 14) ? r % 5 : (r < 19) ? 10 + (r - 14) : MT;
      run_instr(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                wt, $urandom_range(1, 4), $urandom_range(0, 5) == 0);
    end

    fork
      begin : driver
        while (stim_q.size() > 0) begin
          stim_t si;
          @(posedge clk); #1;
          si = stim_q.pop_front();
          reset = si.rst; opcode = si.op; z = si.z; s = si.s;
          mem_ready = si.rdy; irq = si.irq; resume = si.res;
        end
      end
      begin : monitor
        int idx = 0;
        while (exp_q.size() > 0) begin
          obs_t e, a;
          @(negedge clk);
          e = exp_q.pop_front();
          a = '{st: state_dbg, op_alu: op_alu, s_pc: s_pc, s_wd3: s_wd3, s_addr: s_addr,
                s_io_wr: s_io_wr, we_pc: we_pc, we_reg: we_reg, we_alu: we_alu,
                we_rmem: we_rmem, we_wd3: we_wd3, we3: we3, push: push, pop: pop,
                read: read, write: write, irq_ack: irq_ack, halted: halted, fault: fault};
          checks++;
          if (a !== e) begin
            errors++;
            $display("FAIL cycle %0d (exp state %0d): got %h, expected %h", idx, e.st, a, e);
          end
          if (e.st == 4'd0) begin
            checks++;
            if (a !== obs_t'('0)) begin
              errors++;
              $display("FAIL reset state cycle %0d: outputs %h not all zero", idx, a);
            end
          end
          if (e.st == 4'd11 && e.fault == 2'b11) begin
            checks++;
            if (state_dbg !== 4'd11 || fault !== 2'b11 || write !== 1'b0 || read !== 1'b0) begin
              errors++;
              $display("FAIL expired wait cycle %0d: state %0d fault %b write %b read %b",
                       idx, state_dbg, fault, write, read);
            end
          end
          idx++;
        end
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
